mux_scan_ctrl: RTL

- Sequencer that sits directly upstream of the 4:1 select mux and also consumes its output.
- Steps the 2-bit select through channels 0..3 and holds each channel for a programmable dwell.
- Samples the single-bit mux output at the end of each dwell and assembles a 4-bit snapshot.
- Presents the snapshot downstream over a valid/ready handshake.

---
 rtl/mux_scan_ctrl_if.sv | 12 +
 rtl/mux_scan_ctrl.sv | 66 ++++++
 2 files changed

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: start/select/sample/snapshot signals between the scan sequencer, the 4:1 mux and downstream
interface mux_scan_ctrl_if;
  logic       start;
  logic       y;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] snap;
  logic       snap_valid;
  logic       snap_ready;
  modport master (input start, y, snap_ready, output sel, busy, snap, snap_valid);
  modport slave (output start, y, snap_ready, input sel, busy, snap, snap_valid);
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select with a per-channel dwell and assembles a 4-bit snapshot; MUX_SCAN_CONT_EN enables continuous rescanning
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input logic clk,
  input logic rst,
  mux_scan_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_CAPTURE, S_HOLD} state_t;
  localparam logic [7:0] CNT_INIT = 8'(DWELL - 1);
  state_t     state;
  logic [7:0] cnt;
  logic [1:0] ch;
  logic [3:0] acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      ch             <= '0;
      acc            <= '0;
      bus.sel        <= '0;
      bus.busy       <= 1'b0;
      bus.snap       <= '0;
      bus.snap_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state    <= S_DWELL;
          ch       <= '0;
          cnt      <= CNT_INIT;
          bus.sel  <= '0;
          bus.busy <= 1'b1;
        end
        S_DWELL: if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else state <= S_CAPTURE;
        S_CAPTURE: begin
          acc[ch] <= bus.y;
          if (ch != 2'd3) begin
            state   <= S_DWELL;
            ch      <= ch + 2'd1;
            bus.sel <= ch + 2'd1;
            cnt     <= CNT_INIT;
          end else begin
            // Last bit comes straight from y since acc[3] only lands this edge
            state          <= S_HOLD;
            bus.snap       <= {bus.y, acc[2:0]};
            bus.snap_valid <= 1'b1;
          end
        end
        S_HOLD: if (bus.snap_ready) begin
          bus.snap_valid <= 1'b0;
          bus.sel        <= '0;
          ch             <= '0;
`ifdef MUX_SCAN_CONT_EN
          state          <= S_DWELL;
          cnt            <= CNT_INIT;
`else
          state          <= S_IDLE;
          bus.busy       <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
